// File: rtl/cwru_transceiver_rx.sv
// cwru_transceiver_rx: 8N1 UART receiver with HEX0 nibble display; define CWRU_RX_PARITY_EN for 8E1 frames.
module cwru_transceiver_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RX_IN,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic [6:0] HEX0
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`ifdef CWRU_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic [1:0] rst_sync;
  logic rst_n_i;
  logic [SYNC_STAGES-1:0] sync;
  logic rx_s, good;
  logic [CW-1:0] clk_cnt, cnt_n;
  logic [2:0] bit_idx, idx_n;
  logic [7:0] shift, shift_n, rx_data, data_n;
  logic valid_n, ferr_n;
  assign rst_n_i = rst_sync[1];
  assign rx_s = sync[SYNC_STAGES-1];
  assign RX_DATA = rx_data;
`ifdef CWRU_RX_PARITY_EN
  logic par_err, par_n;
  assign good = rx_s & ~par_err;
  always_ff @(posedge CLK or negedge rst_n_i)
    if (!rst_n_i) par_err <= 1'b0;
    else par_err <= par_n;
`else
  assign good = rx_s;
`endif
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  always_ff @(posedge CLK or negedge rst_n_i)
    if (!rst_n_i) begin
      state <= IDLE;
      sync <= '1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      rx_data <= '0;
      RX_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      HEX0 <= 7'b1000000;
    end else begin
      state <= state_n;
      sync <= {sync[SYNC_STAGES-2:0], RX_IN};
      clk_cnt <= cnt_n;
      bit_idx <= idx_n;
      shift <= shift_n;
      rx_data <= data_n;
      RX_VALID <= valid_n;
      FRAME_ERR <= ferr_n;
      HEX0 <= SEG[rx_data[3:0]];
    end
  always_comb begin
    state_n = state;
    cnt_n = clk_cnt + 1'b1;
    idx_n = bit_idx;
    shift_n = shift;
    data_n = rx_data;
    valid_n = 1'b0;
    ferr_n = 1'b0;
`ifdef CWRU_RX_PARITY_EN
    par_n = par_err;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START:
        if (clk_cnt == MID) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      DATA:
        if (clk_cnt == LAST) begin
          cnt_n = '0;
          shift_n[bit_idx] = rx_s;
          idx_n = bit_idx + 1'b1;
          state_n = (bit_idx == 3'd7) ? AFTER_DATA : DATA;
        end
`ifdef CWRU_RX_PARITY_EN
      PARITY:
        if (clk_cnt == LAST) begin
          cnt_n = '0;
          par_n = ^{shift, rx_s};
          state_n = STOP;
        end
`endif
      STOP:
        if (clk_cnt == LAST) begin
          cnt_n = '0;
          valid_n = good;
          ferr_n = ~good;
          data_n = good ? shift : rx_data;
          state_n = rx_s ? IDLE : BREAK;
        end
      BREAK: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: doc/cwru_transceiver_rx.md
Name: cwru_transceiver_rx

Overview:
Receive-side counterpart of the CWRU transceiver transmitter. Samples the serial line arriving on a GPIO_1 pin and recovers 8N1 UART-style frames (idle high, start low, 8 data bits LSB first, stop high). Presents each byte with a one-cycle valid strobe, flags framing errors, and shows the low nibble of the last good byte on the HEX0 seven-segment display. Runs on the 50 MHz board clock.

Parameters:
CLKS_PER_BIT, 434, CLK cycles per bit (50 MHz / 115200); legal range 8..65535.
SYNC_STAGES, 2, flip-flop stages in the RX_IN synchronizer; legal range 2..4.

Ports:
CLK  input  1  system clock, 50 MHz, rising edge.
RESET_N  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line from the GPIO_1 pin; asynchronous to CLK.
RX_DATA  output  8  last received byte; held until the next good frame.
RX_VALID  output  1  one-CLK pulse when RX_DATA updates.
FRAME_ERR  output  1  one-CLK pulse when the stop bit is sampled low.
HEX0  output  7  active-low segments {g,f,e,d,c,b,a} showing RX_DATA[3:0] in hex (0-F).

Behaviour:
- Reset (async assert, sync release): state=IDLE; counters=0; synchronizer flops=1. RX_DATA=8'h00, RX_VALID=0, FRAME_ERR=0, HEX0=7'b1000000 ("0").
- RX_IN passes through SYNC_STAGES flops. All logic uses the synchronized value rx_s.
- Bit counter clk_cnt counts 0..CLKS_PER_BIT-1. Its width is clog2(CLKS_PER_BIT). Bit index bit_idx is 3 bits.
- IDLE: on rx_s==0, go to START with clk_cnt=0.
- START: when clk_cnt reaches (CLKS_PER_BIT-1)/2 (mid-bit), sample rx_s.
  - If rx_s==1 (glitch): return to IDLE. No output.
  - Otherwise: go to DATA with clk_cnt=0 and bit_idx=0.
- DATA: when clk_cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first) and reset clk_cnt. After bit_idx==7 is sampled, go to STOP (or PARITY, see Optional Feature).
- STOP: at a full-bit count, sample rx_s.
  - If rx_s==1: load RX_DATA from shift, pulse RX_VALID on the next cycle, go to IDLE.
  - If rx_s==0: pulse FRAME_ERR, leave RX_DATA unchanged, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. This handles a line held low, so it does not retrigger a start.
- Sampling point is mid-bit for every bit: each data/stop sample falls k*CLKS_PER_BIT after the validated mid-start sample.
- Latency: RX_VALID rises (SYNC_STAGES + 1) cycles after the stop-bit mid-point on the raw line, within ±1 cycle.
- RX_VALID and FRAME_ERR are never high in the same cycle. Each is exactly 1 cycle wide.
- HEX0 is registered from RX_DATA[3:0]. It updates the cycle after RX_DATA changes.
- Back-to-back frames: a start edge that arrives the cycle after STOP returns to IDLE is accepted. There is no dead time beyond a half bit.
- Reset asserted mid-frame: the frame is discarded immediately. No RX_VALID or FRAME_ERR is produced.

Optional Feature:
CWRU_RX_PARITY_EN
- Defined: frame is 8E1. A PARITY state is inserted after DATA and samples the parity bit at a full-bit count.
  - If even parity over data+parity fails: FRAME_ERR pulses at the stop-bit sample, instead of RX_VALID, whatever the stop value.
  - Good parity and stop=1: normal RX_VALID.
- Undefined: no PARITY state; 8N1 exactly as above.

Test Plan:
- Reset, line idle high for 1000 cycles -> RX_VALID=0, FRAME_ERR=0, RX_DATA=8'h00, HEX0=7'b1000000.
- Send 8'hA5 at CLKS_PER_BIT=16 -> exactly one RX_VALID; RX_DATA=8'hA5; HEX0=7'b0010010 ("5").
- Low glitch of 4 cycles on idle line (CLKS_PER_BIT=16) -> no RX_VALID or FRAME_ERR; state back in IDLE; next frame 8'h3C is received correctly.
- Frame 8'h5A with stop bit forced low, then line held low for 3 bit-times, then high -> one FRAME_ERR pulse; RX_DATA still holds the previous value; no spurious frame while low; following 8'h01 gives RX_DATA=8'h01, HEX0=7'b1111001.
- Back-to-back frames 8'h00, 8'hFF, 8'h0F with no idle gap -> three RX_VALID pulses with data in order; HEX0 ends at 7'b0001110 ("F").
- RESET_N pulsed low mid-byte during 8'h77 -> outputs return to reset values at once; no pulses; the next full frame 8'h12 is received.
